// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared definitions for the HD44780 custom-instruction blocks:
//               read FSM state encoding, command/result bit positions and
//               default bus timing (cycles at 50 MHz), which the write
//               instruction uses as well.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_EHIGH   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4,
    ST_DONE    = 3'd5
  } lcd_state_t;

  // Command word (dataa) bit positions
  localparam int CMD_RS   = 0;
  localparam int CMD_POLL = 1;

  // Result word bit positions
  localparam int RES_TIMEOUT = 8;
  localparam int STATUS_BF   = 7;

  // Default bus timing in clock cycles
  localparam int DEF_T_AS      = 3;
  localparam int DEF_T_EH      = 12;
  localparam int DEF_T_H       = 2;
  localparam int DEF_T_REC     = 13;
  localparam int DEF_MAX_POLLS = 4096;

endpackage
`default_nettype wire

// File: rtl/lcd_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_phase_timer
// Description : Down-counter that times one LCD bus phase. Loading N-1 makes
//               `last` assert on the N-th cycle of the phase.
// Ports       : clk, reset_n (sync, active-low), load, load_val -> last
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign last = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_reader.sv
`default_nettype none
// ============================================================================
// Module      : lcd_reader
// Description : Nios II custom instruction performing HD44780 read cycles
//               (status or data), with optional busy-flag polling bounded by
//               MAX_POLLS status reads.
// Ports       : clk, reset_n (sync, active-low), clk_en (start), dataa
//               (command) -> done, result, busy; lcd_en/lcd_rs/lcd_rw drive
//               the LCD, lcd_data_i is the sampled LCD data bus.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int T_AS      = DEF_T_AS,
  parameter int T_EH      = DEF_T_EH,
  parameter int T_H       = DEF_T_H,
  parameter int T_REC     = DEF_T_REC,
  parameter int MAX_POLLS = DEF_MAX_POLLS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result,
  output logic        busy,
  output logic        lcd_en,
  output logic        lcd_rs,
  output logic        lcd_rw,
  input  logic [7:0]  lcd_data_i
);

  localparam int T_MAX12 = (T_AS > T_EH) ? T_AS : T_EH;
  localparam int T_MAX34 = (T_H > T_REC) ? T_H : T_REC;
  localparam int T_MAX   = (T_MAX12 > T_MAX34) ? T_MAX12 : T_MAX34;
  localparam int CW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int PW      = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;

  localparam logic [CW-1:0] C_LD_AS   = CW'(T_AS - 1);
  localparam logic [CW-1:0] C_LD_EH   = CW'(T_EH - 1);
  localparam logic [CW-1:0] C_LD_H    = CW'(T_H - 1);
  localparam logic [CW-1:0] C_LD_REC  = CW'(T_REC - 1);
  localparam logic [PW-1:0] C_POLL_LAST = PW'(MAX_POLLS - 1);

  lcd_state_t    r_state, w_state_nxt;
  logic          r_rs_lat, r_poll, r_phase_rs;
  logic [7:0]    r_byte;
  logic [PW-1:0] r_poll_cnt;
  logic [8:0]    r_result;
  logic          w_load, w_last;
  logic [CW-1:0] w_load_val;
  logic          w_status_poll, w_bf, w_retry, w_timeout, w_to_data;
  logic          w_unused_dataa;

  assign w_unused_dataa = ^dataa[31:2];

  lcd_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_load),
    .load_val (w_load_val),
    .last     (w_last)
  );

  // Decision made at the end of RECOVER, based on the byte just captured
  assign w_status_poll = r_poll & ~r_phase_rs;
  assign w_bf          = r_byte[STATUS_BF];
  assign w_retry       = w_status_poll & w_bf & (r_poll_cnt != C_POLL_LAST);
  assign w_timeout     = w_status_poll & w_bf & (r_poll_cnt == C_POLL_LAST);
  assign w_to_data     = w_status_poll & ~w_bf & r_rs_lat;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; every phase entry is a state change, so the timer is
  // reloaded whenever the state changes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (clk_en) w_state_nxt = ST_SETUP;
      ST_SETUP:   if (w_last) w_state_nxt = ST_EHIGH;
      ST_EHIGH:   if (w_last) w_state_nxt = ST_HOLD;
      ST_HOLD:    if (w_last) w_state_nxt = ST_RECOVER;
      ST_RECOVER: if (w_last) w_state_nxt = (w_retry || w_to_data) ? ST_SETUP : ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase

    w_load     = (w_state_nxt != r_state);
    w_load_val = '0;
    case (w_state_nxt)
      ST_SETUP:   w_load_val = C_LD_AS;
      ST_EHIGH:   w_load_val = C_LD_EH;
      ST_HOLD:    w_load_val = C_LD_H;
      ST_RECOVER: w_load_val = C_LD_REC;
      default:    w_load_val = '0;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    lcd_en = (r_state == ST_EHIGH);
    lcd_rw = 1'b1;
    done   = (r_state == ST_DONE);
    busy   = (r_state != ST_IDLE);
    lcd_rs = 1'b0;
    if (r_state != ST_IDLE && r_state != ST_DONE) lcd_rs = r_phase_rs;
  end

  assign result = {23'd0, r_result};

  // Command latch, byte capture, poll counter and result register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rs_lat   <= 1'b0;
      r_poll     <= 1'b0;
      r_phase_rs <= 1'b0;
      r_byte     <= '0;
      r_poll_cnt <= '0;
      r_result   <= '0;
    end else begin
      if (r_state == ST_IDLE && clk_en) begin
        r_rs_lat   <= dataa[CMD_RS];
        r_poll     <= dataa[CMD_POLL];
        // Polling always begins with a status read regardless of RS
        r_phase_rs <= dataa[CMD_POLL] ? 1'b0 : dataa[CMD_RS];
        r_poll_cnt <= '0;
      end
      if (r_state == ST_EHIGH && w_last) r_byte <= lcd_data_i;
      if (r_state == ST_RECOVER && w_last) begin
        if (w_retry)        r_poll_cnt <= r_poll_cnt + 1'b1;
        else if (w_to_data) r_phase_rs <= 1'b1;
        else                r_result   <= {w_timeout, r_byte};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_reader
// Description : Scoreboard bench for lcd_reader (MAX_POLLS=4). Stimulus pushes
//               the expected result/latency/E-pulse counts; a monitor pops on
//               every done pulse. A small LCD model returns a programmable
//               number of busy statuses before a ready status.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_reader;
  import lcd_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [31:0] dataa = '0;
  logic        done, busy, lcd_en, lcd_rs, lcd_rw;
  logic [31:0] result;
  logic [7:0]  lcd_data_i;

  always #5 clk = ~clk;

  lcd_reader #(.MAX_POLLS(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_en     (clk_en),
    .dataa      (dataa),
    .done       (done),
    .result     (result),
    .busy       (busy),
    .lcd_en     (lcd_en),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_data_i (lcd_data_i)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
    int          st;
    int          dt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_mis = 0;
  int   cyc = 0, acc_cyc = 0, done_cnt = 0;
  int   busy_reads = 0, st_pulses = 0, dt_pulses = 0, rw_bad = 0, hi_cnt = 0;
  logic [7:0] busy_val = 8'h80, final_status = 8'h00, data_val = 8'h00;
  logic pulse_rs = 1'b0;
  bit   skip_width = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // LCD model: the first busy_reads status reads report busy_val
  assign lcd_data_i = lcd_rs ? data_val
                    : ((st_pulses < busy_reads) ? busy_val : final_status);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: E pulse shape and count, RW level, scoreboard on done
  always @(negedge clk) begin
    if (lcd_rw !== 1'b1) rw_bad++;
    if (lcd_en === 1'b1) begin
      hi_cnt++;
      pulse_rs = lcd_rs;
    end else if (hi_cnt != 0) begin
      if (!skip_width) check("e_width", hi_cnt, 12);
      if (pulse_rs) dt_pulses++;
      else          st_pulses++;
      hi_cnt = 0;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_done: got done with result 0x%0h, expected no done", result);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_latency"}, cyc - acc_cyc + 1, e.lat);
        check({e.name, "_status_pulses"}, st_pulses, e.st);
        check({e.name, "_data_pulses"}, dt_pulses, e.dt);
        check({e.name, "_rw_high"}, rw_bad, 0);
      end
    end
  end

  task automatic issue(input logic [31:0] cmd);
    @(negedge clk);
    clk_en = 1'b1;
    dataa  = cmd;
    st_pulses = 0;
    dt_pulses = 0;
    rw_bad    = 0;
    @(negedge clk);
    clk_en  = 1'b0;
    dataa   = 32'hFFFF_FFFF;
    acc_cyc = cyc;
    check("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_done(input int bound);
    int start;
    start = done_cnt;
    for (int i = 0; i < bound && done_cnt == start; i++) @(negedge clk);
    if (done_cnt == start) begin
      n_cmp++;
      n_mis++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected one", bound);
    end
    repeat (3) @(negedge clk);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic run(input string name, input logic [31:0] cmd, input logic [31:0] res,
                     input int lat, input int st, input int dt);
    exp_t e;
    e.name = name; e.res = res; e.lat = lat; e.st = st; e.dt = dt;
    q.push_back(e);
    issue(cmd);
    wait_done(400);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int start;
    exp_t e;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lcd_en", lcd_en, 1'b0);
    check("rst_lcd_rs", lcd_rs, 1'b0);
    check("rst_lcd_rw", lcd_rw, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain status and data reads
    busy_reads = 0; final_status = 8'h25;
    run("status_read", 32'h0, 32'h25, 31, 1, 0);
    data_val = 8'h41;
    run("data_read", 32'h1, 32'h41, 31, 0, 1);

    // Poll mode with the controller already ready
    final_status = 8'h07;
    run("poll_ready", 32'h2, 32'h07, 31, 1, 0);

    // Three busy statuses, then ready, then the data read
    busy_reads = 3; busy_val = 8'h83; final_status = 8'h07; data_val = 8'h5A;
    run("poll_data", 32'h3, 32'h5A, 151, 4, 1);

    // Busy forever: timeout after MAX_POLLS status reads
    busy_reads = 100; busy_val = 8'h80;
    run("poll_timeout", 32'h2, 32'h180, 121, 4, 0);
    run("poll_rs_timeout", 32'h3, 32'h180, 121, 4, 0);

    // Start strobe held high while busy must not queue another command
    busy_reads = 0; data_val = 8'hC3;
    e.name = "held_clk_en"; e.res = 32'hC3; e.lat = 31; e.st = 0; e.dt = 1;
    q.push_back(e);
    start = done_cnt;
    @(negedge clk);
    clk_en = 1'b1; dataa = 32'h1;
    st_pulses = 0; dt_pulses = 0; rw_bad = 0;
    @(negedge clk);
    acc_cyc = cyc;
    dataa = 32'h3;
    repeat (20) @(negedge clk);
    clk_en = 1'b0;
    wait_done(400);
    repeat (40) @(negedge clk);
    check("held_clk_en_done_count", done_cnt - start, 1);

    // Reset while E is high aborts the read without a done pulse
    final_status = 8'h25;
    start = done_cnt;
    issue(32'h0);
    for (int i = 0; i < 20 && lcd_en !== 1'b1; i++) @(negedge clk);
    check("abort_reached_ehigh", lcd_en, 1'b1);
    skip_width = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_lcd_en", lcd_en, 1'b0);
    check("abort_busy", busy, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    skip_width = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - start, 0);
    check("abort_result_cleared", result, 32'h0);

    // Clean read after the abort
    run("post_abort_read", 32'h0, 32'h25, 31, 1, 0);

    check("scoreboard_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_reader.md
Name: lcd_reader

Overview:
Nios II custom-instruction block that performs HD44780 read cycles (RW=1): either a status read (busy flag + address counter) or a data read (DDRAM/CGRAM byte). It is the read-side counterpart of the LCD write instruction and shares the same LCD E/RS/RW pins through top-level muxing. An optional poll mode repeats status reads until BF=0, with a bounded timeout, before returning. Internal phase counters generate all LCD bus timing.

Parameters:
T_AS, 3, cycles RS/RW stable before E rises (≥40 ns at 50 MHz)
T_EH, 12, cycles E held high; data sampled on last E-high cycle (≥230 ns, >tDDR 160 ns)
T_H, 2, cycles RS/RW held after E falls
T_REC, 13, cycles E low before next cycle/done (full cycle ≥500 ns)
MAX_POLLS, 4096, status reads attempted in poll mode before timeout

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active-low
clk_en  in  1  start strobe; sampled only in IDLE
dataa  in  32  command: [0]=RS (0 status, 1 data), [1]=POLL, [31:2] ignored
done  out  1  one-cycle pulse, result valid
result  out  32  [7:0] byte read, [8] timeout, [31:9]=0
busy  out  1  high from start acceptance until done
lcd_en  out  1  LCD E
lcd_rs  out  1  LCD RS
lcd_rw  out  1  LCD RW
lcd_data_i  in  8  LCD D7..D0 (block never drives the bus)

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE, lcd_en=0, lcd_rs=0, lcd_rw=1, done=0, busy=0, result=0, poll counter=0. Reset mid-transaction aborts it; lcd_en falls on that edge, no done.
- States: IDLE, SETUP, EHIGH, HOLD, RECOVER, DONE.
- IDLE: on clk_en=1 latch RS and POLL bits; phase RS = 0 if POLL=1, else latched RS; go SETUP; busy=1.
- SETUP T_AS cycles: lcd_rs=phase RS, lcd_rw=1, lcd_en=0.
- EHIGH T_EH cycles: lcd_en=1; on last cycle capture lcd_data_i into byte register.
- HOLD T_H cycles: lcd_en=0, RS/RW held.
- RECOVER T_REC cycles, then decide:
  - status phase in poll mode, captured bit7=1, poll count < MAX_POLLS-1: increment count, go SETUP (new status read).
  - same but count = MAX_POLLS-1: set timeout, result[7:0]=last status, go DONE.
  - status phase in poll mode, bit7=0, latched RS=1: phase RS=1, go SETUP (data read).
  - otherwise: result[7:0]=captured byte, go DONE.
- DONE one cycle: done=1, busy=0 thereafter; return IDLE. result holds until next done.
- Single read latency: done asserted T_AS+T_EH+T_H+T_REC+1 = 31 cycles after the edge sampling clk_en (defaults).
- clk_en while busy: ignored, no queueing. dataa sampled only at acceptance.
- lcd_rw stays 1 in IDLE; E never pulses outside EHIGH; lcd_en high exactly T_EH consecutive cycles per read.
- Phase counter width = clog2(max(T_AS,T_EH,T_H,T_REC)); poll counter width = clog2(MAX_POLLS). All T_* ≥1.

Decomposition:
- Package lcd_pkg: state enum, dataa bit indices (CMD_RS=0, CMD_POLL=1), result indices (RES_TIMEOUT=8, BF bit 7), default timing constants shared with the write instruction.
- One sub-module natural: lcd_phase_timer (load count, decrement, last-cycle flag); reused by the writer later.

Test Plan:
- Status read, dataa=0x0, lcd_data_i=0x25 -> lcd_rs=0, lcd_rw=1, lcd_en high 12 cycles, done at cycle 31, result=0x00000025.
- Data read, dataa=0x1, lcd_data_i=0x41 -> lcd_rs=1 throughout, result=0x00000041, single E pulse.
- Poll then data, dataa=0x3, BF=1 for 3 status reads then status 0x07, data 0x5A -> 4 status E pulses (rs=0), 1 data pulse (rs=1), result=0x0000005A, done at cycle 5*30+1=151.
- Poll timeout, MAX_POLLS=4, dataa=0x2, lcd_data_i=0x80 fixed -> exactly 4 E pulses, result=0x00000180, done once.
- clk_en=1 repeatedly during transaction -> ignored; exactly one done per accepted command.
- reset_n=0 during EHIGH -> next edge lcd_en=0, busy=0, done never pulses; new clk_en after release starts clean read.
